dalu_sequencer: RTL and testbench

Initiator for the 8-bit ALU. It accepts one instruction at a time over a valid/ready handshake and reads its operands from a 4x8 register file or an immediate. It drives A/B/op to the ALU, captures out/flags, writes the result back, and presents result plus flags on a valid/ready response port. It sits between an instruction source (test harness or future fetch unit) and the combinational ALU.

---
 rtl/dalu_sequencer.sv | 126 ++++++++++++
 tb/tb_dalu_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dalu_sequencer.sv
// rtl/dalu_sequencer.sv - single-issue sequencer driving the 8-bit ALU from a 4x8 register file
// DALU_SEQ_BYPASS_EN removes EXEC and drives the ALU combinationally from the instruction port.
module dalu_sequencer #(
   parameter int NREGS = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [3:0]       instr_op,
   input  logic [1:0]       instr_dst,
   input  logic [1:0]       instr_a,
   input  logic [1:0]       instr_b,
   input  logic             instr_use_imm,
   input  logic [WIDTH-1:0] instr_imm,
   output logic [WIDTH-1:0] alu_A,
   output logic [WIDTH-1:0] alu_B,
   output logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] alu_out,
   input  logic [3:0]       alu_flags,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic [3:0]       res_flags,
   output logic             res_err,
   input  logic [1:0]       dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state;
   logic [WIDTH-1:0] regs [NREGS];
   logic [3:0]       flags_q;
   logic [3:0]       err_flags_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [3:0]       op_q;
   logic [1:0]       dst_q;

   logic             accept;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic             do_capture;
   logic             err_now;
   logic [1:0]       wb_dst;

   assign instr_ready = (state == IDLE);
   assign accept      = instr_valid && instr_ready;
   assign sel_a       = regs[instr_a];
   assign sel_b       = instr_use_imm ? instr_imm : regs[instr_b];
   assign dbg_data    = regs[dbg_addr];

   // Architectural flags are only updated by legal opcodes; an erroring op keeps its own copy.
   assign res_flags   = res_err ? err_flags_q : flags_q;

`ifdef DALU_SEQ_BYPASS_EN
   assign alu_A      = (state == IDLE) ? sel_a : a_q;
   assign alu_B      = (state == IDLE) ? sel_b : b_q;
   assign alu_op     = (state == IDLE) ? instr_op : op_q;
   assign do_capture = accept;
   assign err_now    = instr_op[3];
   assign wb_dst     = instr_dst;
`else
   assign alu_A      = a_q;
   assign alu_B      = b_q;
   assign alu_op     = op_q;
   assign do_capture = (state == EXEC);
   assign err_now    = op_q[3];
   assign wb_dst     = dst_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         flags_q     <= '0;
         err_flags_q <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         dst_q       <= '0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_err     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_q   <= sel_a;
                  b_q   <= sel_b;
                  op_q  <= instr_op;
                  dst_q <= instr_dst;
`ifdef DALU_SEQ_BYPASS_EN
                  state <= RESP;
`else
                  state <= EXEC;
`endif
               end
            end
            EXEC: state <= RESP;
            RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         if (do_capture) begin
            res_valid <= 1'b1;
            res_data  <= alu_out;
            res_err   <= err_now;
            if (err_now) begin
               err_flags_q <= alu_flags;
            end else begin
               flags_q      <= alu_flags;
               regs[wb_dst] <= alu_out;
            end
         end
      end
   end

endmodule

// File: tb/tb_dalu_sequencer.sv
// tb/tb_dalu_sequencer.sv - self-checking bench for dalu_sequencer with a behavioural ALU
module tb_dalu_sequencer;

`ifdef DALU_SEQ_BYPASS_EN
   localparam int LAT = 0;
`else
   localparam int LAT = 1;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       instr_valid, instr_ready;
   logic [3:0] instr_op;
   logic [1:0] instr_dst, instr_a, instr_b;
   logic       instr_use_imm;
   logic [7:0] instr_imm;
   logic [7:0] alu_A, alu_B;
   logic [3:0] alu_op;
   logic [7:0] alu_out;
   logic [3:0] alu_flags;
   logic       res_valid, res_ready;
   logic [7:0] res_data;
   logic [3:0] res_flags;
   logic       res_err;
   logic [1:0] dbg_addr;
   logic [7:0] dbg_data;

   int checks = 0;
   int errors = 0;
   logic [7:0] model_regs [4];

   always #5 clk = ~clk;

   dalu_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_dst(instr_dst), .instr_a(instr_a), .instr_b(instr_b),
      .instr_use_imm(instr_use_imm), .instr_imm(instr_imm),
      .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
      .alu_out(alu_out), .alu_flags(alu_flags),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_flags(res_flags), .res_err(res_err),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   // Returns {flags, out}; flags = {reserved, sign, carry, zero}.
   function automatic logic [11:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] w;
      logic [7:0] r;
      logic       c;
      c = 1'b0;
      case (op)
         4'd0: r = b;
         4'd1: r = a | b;
         4'd2: r = a & b;
         4'd3: r = a ^ b;
         4'd4: r = ~a;
         4'd5: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; end
         4'd6: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8]; end
         4'd7: begin r = {a[6:0], 1'b0}; c = a[7]; end
         default: r = 8'h00;
      endcase
      return {1'b0, r[7], c, (r == 8'h00), r};
   endfunction

   assign {alu_flags, alu_out} = alu(alu_op, alu_A, alu_B);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reg(input logic [1:0] addr, input logic [7:0] exp);
      dbg_addr = addr;
      #1;
      check($sformatf("reg%0d", addr), dbg_data, exp);
   endtask

   task automatic handshake();
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
   endtask

   // Issue one instruction, check latency/operands/stability under backpressure, return the result.
   task automatic run_instr(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] a,
                            input logic [1:0] b, input logic use_imm, input logic [7:0] imm,
                            input int hold, output logic [7:0] d, output logic [3:0] f, output logic e);
      int n;
      logic [7:0] opb;
      logic [11:0] ref_res;
      opb = use_imm ? imm : model_regs[b];
      @(negedge clk);
      n = 0;
      while (!instr_ready && n < 20) begin @(negedge clk); n++; end
      check("ready_before_accept", instr_ready, 1);
      instr_op = op; instr_dst = dst; instr_a = a; instr_b = b;
      instr_use_imm = use_imm; instr_imm = imm; instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      n = 0;
      while (!res_valid && n < 10) begin @(posedge clk); #1; n++; end
      check("latency", n, LAT);
      check("ready_while_busy", instr_ready, 0);
      check("alu_op_held", alu_op, op);
      check("alu_A_held", alu_A, model_regs[a]);
      check("alu_B_held", alu_B, opb);
      d = res_data; f = res_flags; e = res_err;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check("bp_valid", res_valid, 1);
         check("bp_data", res_data, d);
         check("bp_flags", res_flags, f);
         check("bp_ready", instr_ready, 0);
      end
      handshake();
      check("post_hs_valid", res_valid, 0);
      check("post_hs_ready", instr_ready, 1);
      ref_res = alu(op, model_regs[a], opb);
      if (op <= 4'd7) model_regs[dst] = ref_res[7:0];
   endtask

   typedef struct {
      logic [3:0] op;
      logic [1:0] dst, a, b;
      logic       use_imm;
      logic [7:0] imm;
      logic [7:0] exp_data;
      logic [3:0] exp_flags;
      logic       exp_err;
      logic [1:0] chk_reg;
      logic [7:0] exp_reg;
   } vec_t;

   vec_t vecs [11];

   initial begin
      logic [7:0] d;
      logic [3:0] f;
      logic e;
      logic [11:0] exp_res;
      logic [3:0] rop;
      logic [1:0] rdst, ra, rb;
      logic       rimm_en;
      logic [7:0] rimm;
      int n;

      vecs[0]  = '{4'd0,  2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 8'h05, 4'b0000, 1'b0, 2'd1, 8'h05};
      vecs[1]  = '{4'd5,  2'd2, 2'd1, 2'd0, 1'b1, 8'hFB, 8'h00, 4'b0011, 1'b0, 2'd2, 8'h00};
      vecs[2]  = '{4'd6,  2'd3, 2'd1, 2'd0, 1'b1, 8'h07, 8'hFE, 4'b0110, 1'b0, 2'd3, 8'hFE};
      vecs[3]  = '{4'd9,  2'd1, 2'd1, 2'd0, 1'b0, 8'h00, 8'h00, 4'b0001, 1'b1, 2'd1, 8'h05};
      vecs[4]  = '{4'd5,  2'd0, 2'd1, 2'd3, 1'b0, 8'h00, 8'h03, 4'b0010, 1'b0, 2'd0, 8'h03};
      vecs[5]  = '{4'd3,  2'd1, 2'd3, 2'd1, 1'b0, 8'h00, 8'hFB, 4'b0100, 1'b0, 2'd1, 8'hFB};
      vecs[6]  = '{4'd7,  2'd2, 2'd1, 2'd0, 1'b0, 8'h00, 8'hF6, 4'b0110, 1'b0, 2'd2, 8'hF6};
      vecs[7]  = '{4'd4,  2'd3, 2'd0, 2'd0, 1'b0, 8'h00, 8'hFC, 4'b0100, 1'b0, 2'd3, 8'hFC};
      vecs[8]  = '{4'd2,  2'd0, 2'd2, 2'd0, 1'b1, 8'h0F, 8'h06, 4'b0000, 1'b0, 2'd0, 8'h06};
      vecs[9]  = '{4'd1,  2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 8'h06, 4'b0000, 1'b0, 2'd0, 8'h06};
      vecs[10] = '{4'd15, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 8'h00, 4'b0001, 1'b1, 2'd2, 8'hF6};

      rst_n = 1'b0; instr_valid = 1'b0; res_ready = 1'b0;
      instr_op = '0; instr_dst = '0; instr_a = '0; instr_b = '0;
      instr_use_imm = 1'b0; instr_imm = '0; dbg_addr = '0;
      for (int i = 0; i < 4; i++) model_regs[i] = 8'h00;
      #12;
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 8'h00);
      check("rst_res_flags", res_flags, 4'h0);
      check("rst_res_err", res_err, 0);
      check("rst_alu_A", alu_A, 8'h00);
      check("rst_alu_op", alu_op, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_instr_ready", instr_ready, 1);

      for (int i = 0; i < 11; i++) begin
         run_instr(vecs[i].op, vecs[i].dst, vecs[i].a, vecs[i].b, vecs[i].use_imm, vecs[i].imm,
                   (i == 2) ? 5 : 0, d, f, e);
         check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
         check($sformatf("vec%0d_flags", i), f, vecs[i].exp_flags);
         check($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
         check_reg(vecs[i].chk_reg, vecs[i].exp_reg);
      end

      // Instruction offered throughout RESP must only be taken on the edge after the response handshake.
      @(negedge clk);
      instr_op = 4'd0; instr_dst = 2'd0; instr_use_imm = 1'b1; instr_imm = 8'h33; instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      n = 0;
      while (!res_valid && n < 10) begin @(posedge clk); #1; n++; end
      check("bp2_first_valid", res_valid, 1);
      @(negedge clk);
      instr_op = 4'd0; instr_dst = 2'd1; instr_imm = 8'h77; instr_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp2_valid_held", res_valid, 1);
         check("bp2_data_held", res_data, 8'h33);
         check("bp2_not_ready", instr_ready, 0);
      end
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      check("bp2_hs_valid", res_valid, 0);
      check("bp2_hs_not_accepted", instr_ready, 1);
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      n = 0;
      while (!res_valid && n < 10) begin @(posedge clk); #1; n++; end
      check("bp2_second_latency", n, LAT);
      check("bp2_second_data", res_data, 8'h77);
      handshake();
      model_regs[0] = 8'h33;
      model_regs[1] = 8'h77;
      check_reg(2'd0, 8'h33);
      check_reg(2'd1, 8'h77);

      // Reset while the instruction is in flight.
      @(negedge clk);
      instr_op = 4'd0; instr_dst = 2'd2; instr_use_imm = 1'b1; instr_imm = 8'hAA; instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_res_valid", res_valid, 0);
      check("midrst_ready", instr_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         model_regs[i] = 8'h00;
         check_reg(i[1:0], 8'h00);
      end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check("midrst_never_reported", res_valid, 0);
      end

      for (int t = 0; t < 40; t++) begin
         rop = 4'($urandom_range(0, 9));
         rdst = 2'($urandom_range(0, 3));
         ra = 2'($urandom_range(0, 3));
         rb = 2'($urandom_range(0, 3));
         rimm_en = 1'($urandom_range(0, 1));
         rimm = 8'($urandom);
         exp_res = alu(rop, model_regs[ra], rimm_en ? rimm : model_regs[rb]);
         run_instr(rop, rdst, ra, rb, rimm_en, rimm, $urandom_range(0, 3), d, f, e);
         check("rand_data", d, exp_res[7:0]);
         check("rand_flags", f, exp_res[11:8]);
         check("rand_err", e, (rop > 4'd7));
         check_reg(rdst, model_regs[rdst]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
